id_scoreboard: RTL and testbench

Parametrised register scoreboard for the decode stage. Tracks outstanding load-queue writes per integer register with per-register up/down counters, so several loads to the same destination can be in flight at once. Generates the decode stall for RAW hazards and for non-load writes to a pending register, and accepts any number of completion/cancel ports. It sits between the decoder outputs and the decode-stage acknowledge logic, replacing the single-bit loading vector.

---
 rtl/id_scoreboard_pkg.sv | 18 +
 rtl/id_scoreboard_if.sv | 32 +++
 rtl/id_scoreboard_sb_counter.sv | 59 +++++
 rtl/id_scoreboard.sv | 100 ++++++++++
 tb/tb_id_scoreboard.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/id_scoreboard_pkg.sv
// rtl/id_scoreboard_pkg.sv - shared register-address width, zone encodings and width helper
package id_scoreboard_pkg;

   localparam int REG_AW = 5;

   typedef enum logic [2:0] {
      ZONE_ALU    = 3'd0,
      ZONE_LOADQ  = 3'd1,
      ZONE_BRANCH = 3'd2,
      ZONE_CSR    = 3'd3
   } zone_e;

   // Bit width that can hold values 0..v-1, never below one bit.
   function automatic int clog2_min1(input int v);
      return (v < 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/id_scoreboard_if.sv
// rtl/id_scoreboard_if.sv - decode query, issue, clear and status bundle for the scoreboard
interface id_scoreboard_if #(
   parameter int NREGS = 32,
   parameter int NSRC  = 2,
   parameter int NCLR  = 2
);
   logic                clk_en_i;
   logic                qry_valid_i;
   logic [NSRC-1:0]     qry_src_rd_i;
   logic [NSRC*5-1:0]   qry_src_addr_i;
   logic                qry_regd_tgt_i;
   logic [4:0]          qry_regd_addr_i;
   logic                qry_load_i;
   logic                iss_fire_i;
   logic [NCLR-1:0]     clr_valid_i;
   logic [NCLR*5-1:0]   clr_addr_i;
   logic                stall_o;
   logic [NREGS-2:0]    busy_o;
   logic                err_o;

   modport master (
      output clk_en_i, qry_valid_i, qry_src_rd_i, qry_src_addr_i, qry_regd_tgt_i,
             qry_regd_addr_i, qry_load_i, iss_fire_i, clr_valid_i, clr_addr_i,
      input  stall_o, busy_o, err_o
   );

   modport slave (
      input  clk_en_i, qry_valid_i, qry_src_rd_i, qry_src_addr_i, qry_regd_tgt_i,
             qry_regd_addr_i, qry_load_i, iss_fire_i, clr_valid_i, clr_addr_i,
      output stall_o, busy_o, err_o
   );
endinterface

// File: rtl/id_scoreboard_sb_counter.sv
// rtl/id_scoreboard_sb_counter.sv - saturating up/down pending-load counter for one register
module sb_counter
   import id_scoreboard_pkg::*;
#(
   parameter int MAXPEND = 3,
   parameter int NCLR    = 2,
   localparam int CW     = $clog2(MAXPEND + 1),
   localparam int CCW    = clog2_min1(NCLR + 1)
) (
   input  logic           clk_i,
   input  logic           reset_i,
   input  logic           en_i,
   input  logic           inc_i,
   input  logic [CCW-1:0] clr_cnt_i,
   output logic [CW-1:0]  cnt_o,
   output logic           nz_o,
   output logic           max_o,
   output logic           unf_o,
   output logic           ovf_o
);

   logic [CW-1:0] cnt_q, cnt_d;
   int            sum;

   // Net change is evaluated wide and signed, then clamped into 0..MAXPEND.
   always_comb begin
      sum   = int'(cnt_q) + int'(inc_i) - int'(clr_cnt_i);
      cnt_d = cnt_q;
      unf_o = 1'b0;
      ovf_o = 1'b0;
      if (en_i) begin
         if (sum < 0) begin
            cnt_d = '0;
            unf_o = 1'b1;
         end else if (sum > MAXPEND) begin
            cnt_d = CW'(MAXPEND);
            ovf_o = 1'b1;
         end else begin
            cnt_d = CW'(sum);
         end
         if (cnt_q == '0 && clr_cnt_i != '0) begin
            unf_o = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
   assign nz_o  = (cnt_q != '0);
   assign max_o = (cnt_q == CW'(MAXPEND));

endmodule

// File: rtl/id_scoreboard.sv
// rtl/id_scoreboard.sv - per-register pending-load scoreboard producing the decode hazard stall
module id_scoreboard
   import id_scoreboard_pkg::*;
#(
   parameter int  NREGS   = 32,
   parameter int  NSRC    = 2,
   parameter int  NCLR    = 2,
   parameter int  MAXPEND = 3,
   localparam int CW      = $clog2(MAXPEND + 1),
   localparam int CCW     = clog2_min1(NCLR + 1)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   id_scoreboard_if.slave   sb
);

   logic [CW-1:0]           cnt    [1:NREGS-1];
   logic [CCW-1:0]          clr_cnt[1:NREGS-1];
   logic [NREGS-1:1]        inc, nz, at_max, unf, ovf;
   logic [2**REG_AW-1:0]    nz_all, max_all;
   logic                    stall;
   logic                    err_q, err_d;
   logic [REG_AW-1:0]       rd;

   assign rd = sb.qry_regd_addr_i;

   always_comb begin
      for (int r = 1; r < NREGS; r++) begin
         clr_cnt[r] = '0;
         for (int p = 0; p < NCLR; p++) begin
            if (sb.clr_valid_i[p] && sb.clr_addr_i[p*REG_AW +: REG_AW] == REG_AW'(r)) begin
               clr_cnt[r] = clr_cnt[r] + CCW'(1);
            end
         end
      end
   end

   for (genvar r = 1; r < NREGS; r++) begin : g_cnt
      assign inc[r] = sb.iss_fire_i & sb.qry_load_i & sb.qry_regd_tgt_i &
                      (rd == REG_AW'(r));

      sb_counter #(
         .MAXPEND (MAXPEND),
         .NCLR    (NCLR)
      ) u_cnt (
         .clk_i     (clk_i),
         .reset_i   (reset_i),
         .en_i      (sb.clk_en_i),
         .inc_i     (inc[r]),
         .clr_cnt_i (clr_cnt[r]),
         .cnt_o     (cnt[r]),
         .nz_o      (nz[r]),
         .max_o     (at_max[r]),
         .unf_o     (unf[r]),
         .ovf_o     (ovf[r])
      );
   end

   // x0 and any address beyond NREGS-1 read as never pending.
   always_comb begin
      nz_all  = '0;
      max_all = '0;
      for (int r = 1; r < NREGS; r++) begin
         nz_all[r]  = (cnt[r] != '0);
         max_all[r] = at_max[r];
      end
   end

   // iss_fire_i is deliberately absent here: decode derives it from stall_o.
   always_comb begin
      stall = 1'b0;
      if (sb.qry_valid_i) begin
         for (int k = 0; k < NSRC; k++) begin
            if (sb.qry_src_rd_i[k] && nz_all[sb.qry_src_addr_i[k*REG_AW +: REG_AW]]) begin
               stall = 1'b1;
            end
         end
         if (sb.qry_regd_tgt_i) begin
            if (sb.qry_load_i ? max_all[rd] : nz_all[rd]) begin
               stall = 1'b1;
            end
         end
      end
   end

   assign err_d = err_q | (|unf) | (|ovf);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign sb.stall_o = stall;
   assign sb.busy_o  = nz;
   assign sb.err_o   = err_q;

endmodule

// File: tb/tb_id_scoreboard.sv
// tb/tb_id_scoreboard.sv - table-driven scoreboard bench for id_scoreboard
module tb_id_scoreboard;

   typedef struct {
      logic       valid;
      logic [1:0] srd;
      logic [4:0] s0, s1;
      logic       tgt;
      logic [4:0] rd;
      logic       load, fire;
      logic [1:0] cv;
      logic [4:0] c0, c1;
      logic       en;
      logic       exp_stall;
      logic [30:0] exp_busy;
      logic       exp_err;
   } vec_t;

   typedef struct {
      logic [30:0] busy;
      logic        err;
      string       nm;
   } exp_t;

   logic clk, rst;
   int   ncmp, nfail;
   vec_t tbl[$];
   exp_t sb_q[$];

   id_scoreboard_if #(.NREGS(32), .NSRC(2), .NCLR(2)) ifc ();

   id_scoreboard #(.NREGS(32), .NSRC(2), .NCLR(2), .MAXPEND(3)) dut (
      .clk_i   (clk),
      .reset_i (rst),
      .sb      (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [30:0] b(input int r);
      logic [30:0] one;
      one = 31'(1);
      return one << (r - 1);
   endfunction

   function automatic vec_t v(input logic valid, input logic [1:0] srd, input int s0, input int s1,
                              input logic tgt, input int rd, input logic load, input logic fire,
                              input logic [1:0] cv, input int c0, input int c1, input logic en,
                              input logic st, input logic [30:0] bz, input logic er);
      vec_t t;
      t.valid = valid; t.srd = srd; t.s0 = 5'(s0); t.s1 = 5'(s1);
      t.tgt = tgt; t.rd = 5'(rd); t.load = load; t.fire = fire;
      t.cv = cv; t.c0 = 5'(c0); t.c1 = 5'(c1); t.en = en;
      t.exp_stall = st; t.exp_busy = bz; t.exp_err = er;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle();
      ifc.clk_en_i = 1'b1; ifc.qry_valid_i = 1'b0; ifc.qry_src_rd_i = '0;
      ifc.qry_src_addr_i = '0; ifc.qry_regd_tgt_i = 1'b0; ifc.qry_regd_addr_i = '0;
      ifc.qry_load_i = 1'b0; ifc.iss_fire_i = 1'b0; ifc.clr_valid_i = '0; ifc.clr_addr_i = '0;
   endtask

   task automatic step(input vec_t t, input string nm);
      exp_t e;
      @(negedge clk);
      ifc.clk_en_i = t.en; ifc.qry_valid_i = t.valid; ifc.qry_src_rd_i = t.srd;
      ifc.qry_src_addr_i = {t.s1, t.s0}; ifc.qry_regd_tgt_i = t.tgt; ifc.qry_regd_addr_i = t.rd;
      ifc.qry_load_i = t.load; ifc.iss_fire_i = t.fire; ifc.clr_valid_i = t.cv;
      ifc.clr_addr_i = {t.c1, t.c0};
      #1;
      chk($sformatf("%s stall", nm), 32'(ifc.stall_o), 32'(t.exp_stall));
      e.busy = t.exp_busy; e.err = t.exp_err; e.nm = nm;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         chk($sformatf("%s queue", nm), 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         chk($sformatf("%s busy", e.nm), 32'(ifc.busy_o), 32'(e.busy));
         chk($sformatf("%s err", e.nm), 32'(ifc.err_o), 32'(e.err));
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ncmp = 0; nfail = 0;
      rst = 1'b1;
      idle();
      repeat (2) @(negedge clk);
      rst = 1'b0;

      //        vld srd   s0 s1 tgt rd ld fr cv    c0 c1 en  st busy   err
      tbl.push_back(v(1, 2'b01, 5, 0, 1, 1, 0, 0, 2'b00, 0, 0, 1,  0, 0,      0));
      tbl.push_back(v(1, 2'b00, 0, 0, 1, 5, 1, 1, 2'b00, 0, 0, 1,  0, b(5),   0));
      tbl.push_back(v(1, 2'b01, 5, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1,  1, b(5),   0));
      tbl.push_back(v(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1,  0, b(5),   0));
      tbl.push_back(v(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1,  0, b(5),   0));
      tbl.push_back(v(1, 2'b10, 0, 5, 0, 0, 0, 0, 2'b01, 5, 0, 1,  1, 0,      0));
      tbl.push_back(v(1, 2'b10, 0, 5, 0, 0, 0, 0, 2'b00, 0, 0, 1,  0, 0,      0));
      tbl.push_back(v(1, 2'b00, 0, 0, 1, 7, 1, 1, 2'b00, 0, 0, 1,  0, b(7),   0));
      tbl.push_back(v(1, 2'b00, 0, 0, 1, 7, 1, 1, 2'b00, 0, 0, 1,  0, b(7),   0));
      tbl.push_back(v(1, 2'b00, 0, 0, 1, 7, 1, 1, 2'b00, 0, 0, 1,  0, b(7),   0));
      tbl.push_back(v(1, 2'b00, 0, 0, 1, 7, 1, 0, 2'b00, 0, 0, 1,  1, b(7),   0));
      tbl.push_back(v(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b11, 7, 7, 1,  0, b(7),   0));
      tbl.push_back(v(1, 2'b00, 0, 0, 1, 7, 0, 0, 2'b01, 7, 0, 1,  1, 0,      0));
      tbl.push_back(v(1, 2'b00, 0, 0, 1, 7, 0, 0, 2'b00, 0, 0, 1,  0, 0,      0));
      tbl.push_back(v(1, 2'b00, 0, 0, 1, 9, 1, 1, 2'b00, 0, 0, 1,  0, b(9),   0));
      tbl.push_back(v(1, 2'b00, 0, 0, 1, 9, 1, 1, 2'b11, 9, 9, 1,  0, 0,      0));
      tbl.push_back(v(1, 2'b00, 0, 0, 1, 0, 1, 1, 2'b00, 0, 0, 1,  0, 0,      0));
      tbl.push_back(v(1, 2'b11, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 1,  0, 0,      0));
      tbl.push_back(v(1, 2'b00, 0, 0, 1, 3, 1, 1, 2'b00, 0, 0, 0,  0, 0,      0));
      tbl.push_back(v(1, 2'b00, 0, 0, 1, 3, 1, 1, 2'b01, 8, 0, 0,  0, 0,      0));
      tbl.push_back(v(1, 2'b01, 3, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1,  0, 0,      0));
      tbl.push_back(v(1, 2'b00, 0, 0, 1, 2, 1, 1, 2'b00, 0, 0, 1,  0, b(2),   0));
      tbl.push_back(v(1, 2'b00, 2, 2, 0, 0, 0, 0, 2'b00, 0, 0, 1,  0, b(2),   0));
      tbl.push_back(v(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 2, 0, 0,  0, b(2),   0));
      tbl.push_back(v(0, 2'b01, 2, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1,  0, b(2),   0));
      tbl.push_back(v(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 0, 2, 1,  0, 0,      0));
      tbl.push_back(v(1, 2'b00, 0, 0, 1, 31, 1, 1, 2'b00, 0, 0, 1, 0, b(31),  0));
      tbl.push_back(v(1, 2'b10, 0, 31, 0, 0, 0, 0, 2'b00, 0, 0, 1, 1, b(31),  0));
      tbl.push_back(v(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 0, 31, 1, 0, 0,      0));

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i], $sformatf("row%0d", i));
      end

      // Load plus double clear at zero count: net -1 is an underflow.
      step(v(1, 2'b00, 0, 0, 1, 9, 1, 1, 2'b11, 9, 9, 1, 0, 0, 1), "simul_zero");
      step(v(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 0, 1), "err_sticky");
      do_reset();
      step(v(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 0, 0), "err_reset");

      // Overflow: fourth load fired past MAXPEND saturates at 3.
      for (int i = 0; i < 3; i++)
         step(v(1, 2'b00, 0, 0, 1, 7, 1, 1, 2'b00, 0, 0, 1, 0, b(7), 0), $sformatf("ovf_fill%0d", i));
      step(v(1, 2'b00, 0, 0, 1, 7, 1, 1, 2'b00, 0, 0, 1, 1, b(7), 1), "ovf_fire");
      step(v(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b11, 7, 7, 1, 0, b(7), 1), "ovf_sat");
      step(v(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 7, 0, 1, 0, 0, 1), "ovf_drain");
      do_reset();

      // Dual clear of one register, then clear of an idle register.
      step(v(1, 2'b00, 0, 0, 1, 4, 1, 1, 2'b00, 0, 0, 1, 0, b(4), 0), "dual_a");
      step(v(1, 2'b00, 0, 0, 1, 4, 1, 1, 2'b00, 0, 0, 1, 0, b(4), 0), "dual_b");
      step(v(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b11, 4, 4, 1, 0, 0, 0), "dual_clr");
      step(v(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 6, 0, 1, 0, 0, 1), "unrel_clr");
      do_reset();

      // Asynchronous reset mid-operation with x5 at count 2.
      step(v(1, 2'b00, 0, 0, 1, 5, 1, 1, 2'b00, 0, 0, 1, 0, b(5), 0), "mid_a");
      step(v(1, 2'b00, 0, 0, 1, 5, 1, 1, 2'b00, 0, 0, 1, 0, b(5), 0), "mid_b");
      @(negedge clk);
      idle();
      ifc.qry_valid_i = 1'b1; ifc.qry_src_rd_i = 2'b01; ifc.qry_src_addr_i = 10'd5;
      #1;
      chk("mid_pre stall", 32'(ifc.stall_o), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("mid_rst busy", 32'(ifc.busy_o), 32'd0);
      chk("mid_rst stall", 32'(ifc.stall_o), 32'd0);
      chk("mid_rst err", 32'(ifc.err_o), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      step(v(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 5, 0, 1, 0, 0, 1), "post_rst_clr");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
